key_ctrl: RTL and testbench

KEY_CTRL -- requirements
Module: key_ctrl

---
 rtl/key_ctrl_pkg.sv | 6 +
 rtl/key_debounce.sv | 47 ++++
 rtl/key_ctrl.sv | 64 ++++++
 tb/tb_key_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/key_ctrl_pkg.sv
// key_ctrl_pkg: mode enumeration and default timing constants for the key controller.
package key_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, EAT} state_e;
    localparam int DEBOUNCE_CYCLES_DEF = 2000000;
    localparam int EAT_TIMEOUT_DEF = 500000000;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer, counting debouncer and rising-edge press strobe.
module key_debounce
    import key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);
    logic sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d;
    logic press_q, press_d, lock_q, lock_d, hit;
    logic [1:0] fill_q, fill_d;
    logic [31:0] cnt_q, cnt_d;
    always_comb begin
        sync1_d = key;
        sync2_d = sync1_q;
        fill_d = {fill_q[0], 1'b1};
        hit = (sync2_q != stable_q) && (cnt_q == 32'(DEBOUNCE_CYCLES - 1));
        cnt_d = (sync2_q == stable_q || hit) ? '0 : cnt_q + {31'd0, ~&cnt_q};
        stable_d = hit ? sync2_q : stable_q;
        press_d = stable_d & ~stable_q & ~lock_q;
        // A key already held through reset stays locked until it is seen released.
        lock_d = lock_q & ~(fill_q[1] & ~sync2_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            stable_q <= 1'b0;
            cnt_q <= '0;
            press_q <= 1'b0;
            fill_q <= '0;
            lock_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            stable_q <= stable_d;
            cnt_q <= cnt_d;
            press_q <= press_d;
            fill_q <= fill_d;
            lock_q <= lock_d;
        end
    end
    assign press = press_q;
endmodule

// File: rtl/key_ctrl.sv
// key_ctrl: debounces three push-buttons and drives the IDLE/RUN/EAT mode FSM and direction toggle.
module key_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int EAT_TIMEOUT = EAT_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_run,
    input  logic       key_eat,
    input  logic       key_lh,
    output logic       run,
    output logic       eat,
    output logic       lh,
    output logic [2:0] press
);
    logic [2:0] keys, p;
    state_e state_q, state_d;
    logic [31:0] tmo_q, tmo_d;
    logic run_q, run_d, eat_q, eat_d, lh_q, lh_d;
    assign keys = {key_lh, key_eat, key_run};
    for (genvar i = 0; i < 3; i++) begin : g_db
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk),
            .reset(reset),
            .key(keys[i]),
            .press(p[i])
        );
    end
    always_comb begin
        state_d = state_q;
        // Eat press wins over a simultaneous run press; any press wins over timeout.
        if (p[1])
            state_d = (state_q == EAT) ? IDLE : EAT;
        else if (p[0])
            state_d = (state_q == RUN) ? IDLE : RUN;
        else if (state_q == EAT && tmo_q == 32'(EAT_TIMEOUT - 1))
            state_d = IDLE;
        tmo_d = (state_q == EAT && state_d == EAT) ? tmo_q + {31'd0, ~&tmo_q} : '0;
        run_d = state_d == RUN;
        eat_d = state_d == EAT;
        lh_d = lh_q ^ p[2];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tmo_q <= '0;
            run_q <= 1'b0;
            eat_q <= 1'b0;
            lh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q <= tmo_d;
            run_q <= run_d;
            eat_q <= eat_d;
            lh_q <= lh_d;
        end
    end
    assign run = run_q;
    assign eat = eat_q;
    assign lh = lh_q;
    assign press = p;
endmodule

// File: tb/tb_key_ctrl.sv
// tb_key_ctrl: directed and random key stimulus scored against a behavioural model of the controller.
module tb_key_ctrl;
    localparam int DB = 4;
    localparam int TO = 20;
    logic clk = 1'b0, reset = 1'b1;
    logic key_run = 1'b0, key_eat = 1'b0, key_lh = 1'b0;
    logic run, eat, lh;
    logic [2:0] press;
    int vectors = 0, miscompares = 0;
    logic [5:0] exp_q[$];
    key_ctrl #(.DEBOUNCE_CYCLES(DB), .EAT_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .key_run(key_run), .key_eat(key_eat), .key_lh(key_lh),
        .run(run), .eat(eat), .lh(lh), .press(press)
    );
    always #5 clk = ~clk;
    // Reference: raw samples pass a two-sample delay, a key flips after DB consecutive differing samples.
    logic pipe[3][2];
    logic stab[3], held[3];
    int diff_run[3];
    int since_rst;
    int mode, eat_time;
    logic lhm;
    logic [2:0] pr;
    task automatic step();
        logic [2:0] k, npr;
        logic samp, old_stab;
        k = {key_lh, key_eat, key_run};
        npr = '0;
        if (reset) begin
            for (int j = 0; j < 3; j++) begin
                pipe[j][0] = 0; pipe[j][1] = 0; stab[j] = 0; held[j] = 1; diff_run[j] = 0;
            end
            since_rst = 0; mode = 0; eat_time = 0; lhm = 0; pr = '0;
        end else begin
            for (int j = 0; j < 3; j++) begin
                samp = pipe[j][1];
                old_stab = stab[j];
                diff_run[j] = (samp != stab[j]) ? diff_run[j] + 1 : 0;
                if (diff_run[j] == DB) begin
                    stab[j] = samp;
                    diff_run[j] = 0;
                end
                npr[j] = stab[j] && !old_stab && !held[j];
                if (since_rst >= 2 && !samp) held[j] = 0;
                pipe[j][1] = pipe[j][0];
                pipe[j][0] = k[j];
            end
            begin
                int nm;
                nm = mode;
                if (pr[1]) nm = (mode == 2) ? 0 : 2;
                else if (pr[0]) nm = (mode == 1) ? 0 : 1;
                else if (mode == 2 && eat_time == TO - 1) nm = 0;
                eat_time = (mode == 2 && nm == 2) ? eat_time + 1 : 0;
                mode = nm;
            end
            lhm = lhm ^ pr[2];
            pr = npr;
            if (since_rst < 10) since_rst++;
        end
        @(posedge clk);
        exp_q.push_back({mode == 1, mode == 2, lhm, pr});
        #1;
    endtask
    task automatic hold(input logic [2:0] k, input logic r, input int n);
        for (int c = 0; c < n; c++) begin
            {key_lh, key_eat, key_run} = k;
            reset = r;
            step();
        end
    endtask
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            e = exp_q.pop_front();
            vectors++;
            if ({run, eat, lh, press} !== e || (run && eat)) begin
                miscompares++;
                $display("FAIL outputs @%0t: got run=%b eat=%b lh=%b press=%b, expected run=%b eat=%b lh=%b press=%b",
                         $time, run, eat, lh, press, e[5], e[4], e[3], e[2:0]);
            end
        end
    end
    initial begin
        hold(3'b000, 1, 3);
        hold(3'b000, 0, 5);
        hold(3'b001, 0, 10); hold(3'b000, 0, 10);
        hold(3'b001, 0, 10); hold(3'b000, 0, 10);
        hold(3'b010, 0, 3); hold(3'b000, 0, 10);
        hold(3'b001, 0, 10); hold(3'b000, 0, 10);
        hold(3'b010, 0, 10); hold(3'b000, 0, 30);
        hold(3'b011, 0, 10); hold(3'b000, 0, 10);
        hold(3'b100, 0, 10); hold(3'b000, 0, 10);
        hold(3'b100, 0, 10); hold(3'b000, 0, 10);
        hold(3'b010, 0, 10); hold(3'b000, 0, 10);
        hold(3'b010, 0, 10); hold(3'b010, 1, 3); hold(3'b010, 0, 15);
        hold(3'b000, 0, 10); hold(3'b010, 0, 10); hold(3'b000, 0, 10);
        hold(3'b010, 0, 4); hold(3'b000, 0, TO - 2); hold(3'b001, 0, 10); hold(3'b000, 0, 10);
        for (int s = 0; s < 400; s++) begin
            logic [2:0] k;
            k = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            hold(k, $urandom_range(0, 59) == 0, $urandom_range(1, 12));
        end
        hold(3'b000, 0, 3);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
